rf_access_arbiter: RTL and testbench
====================================

Name: rf_access_arbiter

Overview:
- Sequences and shares the single-ported 32x32 register file between two requesters (port 0, port 1).
- The register file does either a dual read (ReadWriteEn=1) or a single write (ReadWriteEn=0) per clock edge. This block issues exactly one operation per cycle.
- After reset it runs an init sweep that writes INIT_VALUE to every register. It then arbitrates round-robin and returns read data with a valid strobe.
- It sits between the pipeline's operand-fetch/writeback stages and the register file.

Parameters:
- NUM_REGS, 32, number of registers swept during init.
- ADDR_W, 5, register address width.
- DATA_W, 32, data width.
- INIT_VALUE, 0, value written to every register during init.
- PROTECT_R0, 1, when 1, post-init writes to address 0 are accepted but not issued to the register file.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- reqN_valid  in  1  (N=0,1) request present.
- reqN_write  in  1  1=write, 0=dual read.
- reqN_addr1  in  ADDR_W  read address 1, or write address.
- reqN_addr2  in  ADDR_W  read address 2 (ignored on write).
- reqN_wdata  in  DATA_W  write data.
- reqN_ready  out  1  request accepted this cycle (combinational).
- rspN_valid  out  1  read data valid.
- rspN_data1  out  DATA_W  read data for addr1.
- rspN_data2  out  DATA_W  read data for addr2.
- init_done  out  1  init sweep complete.
- rf_rw_en  out  1  to register file ReadWriteEn: 1=read, 0=write.
- rf_raddr1, rf_raddr2  out  ADDR_W  register file read addresses.
- rf_waddr  out  ADDR_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- rf_rdata1, rf_rdata2  in  DATA_W  register file registered read data.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Idle-safe rule: rf_rw_en=0 causes a write, so whenever no write is being issued, rf_rw_en=1, rf_raddr1=rf_raddr2=0.
- States: INIT, RUN.
- While rst=1: state<=INIT, init counter<=0, rr pointer<=0, init_done=0, rsp0_valid=rsp1_valid=0, reqN_ready=0, rf_rw_en=1.
- INIT, entered on the first cycle after rst deasserts:
  - Each cycle drives rf_rw_en=0, rf_waddr=counter, rf_wdata=INIT_VALUE, then counter++.
  - After the write of address NUM_REGS-1 the state goes to RUN (NUM_REGS cycles total).
  - init_done goes 1 on entry to RUN.
  - reqN_ready=0 throughout; PROTECT_R0 does not apply during INIT.
- RUN, arbitration:
  - Grant is combinational from reqN_valid and the rr pointer.
  - Single requester valid: it is granted.
  - Both valid: grant the port the pointer favours; the pointer then flips to the other port.
  - Pointer is unchanged on cycles with no grant.
  - reqN_ready=1 only for the granted port; a transfer occurs when valid&&ready.
  - The requester holds valid and payload stable until ready; ready may depend on valid.
- Granted write: rf_rw_en=0, rf_waddr=addr1, rf_wdata=wdata. No response is generated.
  - If PROTECT_R0=1 and addr1==0: handshake completes, rf_rw_en stays 1 (no write).
- Granted read: rf_rw_en=1, rf_raddr1/2=addr1/addr2.
  - Next cycle: rspN_valid=1 for exactly one cycle, with rspN_data1/2 = rf_rdata1/2 passed through.
  - Latency is 1 cycle from accept to rsp_valid.
  - The response port is tracked by a registered tag.
  - Responses cannot be back-pressured.
- Read after write: a read accepted in the cycle after a write to the same address returns the new data, because the write completes at the earlier edge. No forwarding is required. Same-cycle read and write is impossible (one grant per cycle).
- Back-to-back reads from the same port every cycle give a full-throughput rsp_valid stream.
- rsp data outputs are don't-care when rsp_valid=0.
- Reset mid-operation:
  - Reset during INIT restarts the sweep at address 0.
  - Reset with a read in flight: rsp_valid is forced to 0 the next cycle and the read is dropped.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release → exactly 32 write cycles, addresses 0..31 with data 0, then init_done=1 and rf_rw_en=1 with no further writes.
- Port0 writes 0x12345678 to r5, then port1 writes 0xabcdabcd to r15, then port0 reads (5,15) → rsp0_valid one cycle after accept with data1=0x12345678, data2=0xabcdabcd.
- Both ports valid reading every cycle for 6 cycles → grants alternate 0,1,0,1,0,1; each rspN_valid follows its grant by 1 cycle; neither port starves.
- PROTECT_R0=1: port1 writes 0xFFFFFFFF to r0, then reads (0,0) → handshake completes, no register file write issued, read returns 0.
- Write r7=0x55 accepted at cycle t, read (7,7) accepted at t+1 → data 0x55/0x55 at t+2.
- rst asserted mid-INIT at address 10, and separately with a read in flight → sweep restarts at 0; no rsp_valid is emitted for the dropped read.

Source files
------------

// File: rtl/rf_access_arbiter.sv
// rf_access_arbiter
// Shares a single-ported register file between two requesters. After reset
// it sweeps INIT_VALUE into every register. Once the sweep is done it grants
// one request per cycle, round-robin on contention. Read data comes back one
// cycle after acceptance with a one-cycle valid strobe on the requesting port.
module rf_access_arbiter #(
  parameter int                NUM_REGS   = 32,
  parameter int                ADDR_W     = 5,
  parameter int                DATA_W     = 32,
  parameter logic [DATA_W-1:0] INIT_VALUE = '0,
  parameter bit                PROTECT_R0 = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  // requester port 0
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr1,
  input  logic [ADDR_W-1:0] req0_addr2,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  // requester port 1
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr1,
  input  logic [ADDR_W-1:0] req1_addr2,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  // read responses
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data1,
  output logic [DATA_W-1:0] rsp0_data2,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data1,
  output logic [DATA_W-1:0] rsp1_data2,
  // status
  output logic              init_done,
  // register file side
  output logic              rf_rw_en,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2
);

  localparam logic [0:0]        ST_INIT   = 1'b0;
  localparam logic [0:0]        ST_RUN    = 1'b1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_init_cnt;
  logic              r_rr_ptr;     // port favoured on the next contention
  logic              r_rsp_valid;  // a read was issued at the last edge
  logic              r_rsp_tag;    // port that issued that read

  logic [1:0]        w_req_valid;
  logic [1:0]        w_grant;
  logic              w_gnt_port;
  logic              w_any_grant;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr1;
  logic [ADDR_W-1:0] w_sel_addr2;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_r0;
  logic              w_do_write;
  logic              w_do_read;
  logic              w_running;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_running   = (r_state == ST_RUN) && !rst;

  // Round-robin grant: a lone requester wins, contention goes to the pointer.
  always_comb begin
    w_grant = 2'b00;
    if (w_running) begin
      if (w_req_valid == 2'b11) begin
        w_grant[r_rr_ptr] = 1'b1;
      end else begin
        w_grant = w_req_valid;
      end
    end
  end

  assign w_any_grant = |w_grant;
  assign w_gnt_port  = w_grant[1];
  assign req0_ready  = w_grant[0];
  assign req1_ready  = w_grant[1];

  // Payload of the granted port.
  assign w_sel_write = w_gnt_port ? req1_write : req0_write;
  assign w_sel_addr1 = w_gnt_port ? req1_addr1 : req0_addr1;
  assign w_sel_addr2 = w_gnt_port ? req1_addr2 : req0_addr2;
  assign w_sel_wdata = w_gnt_port ? req1_wdata : req0_wdata;

  // A write to r0 still handshakes but is swallowed when protection is on.
  assign w_sel_r0   = PROTECT_R0 && (w_sel_addr1 == '0);
  assign w_do_write = w_any_grant && w_sel_write && !w_sel_r0;
  assign w_do_read  = w_any_grant && !w_sel_write;

  // Register file command; the default is a harmless read of r0 because
  // rf_rw_en low would commit a write.
  always_comb begin
    rf_rw_en  = 1'b1;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    if (!rst) begin
      if (r_state == ST_INIT) begin
        rf_rw_en = 1'b0;
        rf_waddr = r_init_cnt;
        rf_wdata = INIT_VALUE;
      end else if (w_do_write) begin
        rf_rw_en = 1'b0;
        rf_waddr = w_sel_addr1;
        rf_wdata = w_sel_wdata;
      end else if (w_do_read) begin
        rf_raddr1 = w_sel_addr1;
        rf_raddr2 = w_sel_addr2;
      end
    end
  end

  // Init sweep: one register per cycle, then switch to normal service.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + 1'b1;
      if (r_init_cnt == LAST_ADDR) begin
        r_state <= ST_RUN;
      end
    end
  end

  // Fairness pointer moves only when both ports competed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
    end else if (w_running && (w_req_valid == 2'b11)) begin
      r_rr_ptr <= ~r_rr_ptr;
    end
  end

  // Remember which port owns the data the register file returns next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_tag   <= 1'b0;
    end else begin
      r_rsp_valid <= w_do_read;
      r_rsp_tag   <= w_gnt_port;
    end
  end

  // Status and responses are masked while reset is held so an in-flight
  // read never surfaces.
  assign init_done  = w_running;
  assign rsp0_valid = r_rsp_valid && !r_rsp_tag && !rst;
  assign rsp1_valid = r_rsp_valid &&  r_rsp_tag && !rst;
  assign rsp0_data1 = rf_rdata1;
  assign rsp0_data2 = rf_rdata2;
  assign rsp1_data1 = rf_rdata1;
  assign rsp1_data2 = rf_rdata2;

endmodule

// File: tb/tb_rf_access_arbiter.sv
// Scoreboard bench for rf_access_arbiter with a behavioural register file.
module tb_rf_access_arbiter;

  localparam int          NR   = 32;
  localparam logic [31:0] INIT = 32'h0;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req0_valid, req0_write, req0_ready;
  logic [4:0]  req0_addr1, req0_addr2;
  logic [31:0] req0_wdata;
  logic        req1_valid, req1_write, req1_ready;
  logic [4:0]  req1_addr1, req1_addr2;
  logic [31:0] req1_wdata;
  logic        rsp0_valid, rsp1_valid;
  logic [31:0] rsp0_data1, rsp0_data2, rsp1_data1, rsp1_data2;
  logic        init_done, rf_rw_en;
  logic [4:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_wdata, rf_rdata1, rf_rdata2;

  rf_access_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr1(req0_addr1),
    .req0_addr2(req0_addr2), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr1(req1_addr1),
    .req1_addr2(req1_addr2), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_data1(rsp0_data1), .rsp0_data2(rsp0_data2),
    .rsp1_valid(rsp1_valid), .rsp1_data1(rsp1_data1), .rsp1_data2(rsp1_data2),
    .init_done(init_done), .rf_rw_en(rf_rw_en),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2)
  );

  // Behavioural single-ported register file with registered read.
  logic [31:0] rf_mem [NR];
  always @(posedge clk) begin
    if (!rf_rw_en) rf_mem[rf_waddr] <= rf_wdata;
    else begin
      rf_rdata1 <= rf_mem[rf_raddr1];
      rf_rdata2 <= rf_mem[rf_raddr2];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        v;
    logic        w;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] wd;
  } req_t;

  typedef struct {
    int          cyc;
    logic        rdy0;
    logic        rdy1;
    logic        done;
    logic        rw;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [4:0]  wa;
    logic [31:0] wd;
  } op_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] d1;
    logic [31:0] d2;
  } rsp_exp_t;

  op_exp_t  q_op[$];
  rsp_exp_t q_rsp0[$];
  rsp_exp_t q_rsp1[$];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: architectural register contents, init progress,
  // and which port wins the next tie.
  logic [31:0] m_mem [NR];
  int          m_init_idx = 0;
  bit          m_run = 1'b0;
  bit          m_ptr = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  function automatic req_t idle();
    req_t q;
    q.v = 1'b0; q.w = 1'b0; q.a1 = '0; q.a2 = '0; q.wd = '0;
    return q;
  endfunction

  function automatic req_t wr(input logic [4:0] a, input logic [31:0] d);
    req_t q;
    q = idle(); q.v = 1'b1; q.w = 1'b1; q.a1 = a; q.wd = d;
    return q;
  endfunction

  function automatic req_t rd(input logic [4:0] a1, input logic [4:0] a2);
    req_t q;
    q = idle(); q.v = 1'b1; q.a1 = a1; q.a2 = a2;
    return q;
  endfunction

  function automatic req_t rnd_req();
    req_t q;
    q.v  = ($urandom_range(0, 9) < 7);
    q.w  = ($urandom_range(0, 2) == 0);
    q.a1 = 5'($urandom_range(0, 31));
    q.a2 = 5'($urandom_range(0, 31));
    q.wd = $urandom();
    return q;
  endfunction

  // Drive one cycle and record what the model says the DUT must do in it.
  task automatic step(input logic r, input req_t p0, input req_t p1, output logic [1:0] acc);
    op_exp_t  e;
    rsp_exp_t rs;
    logic [1:0] g;
    req_t p;
    @(posedge clk); #1;
    rst = r;
    req0_valid = p0.v; req0_write = p0.w; req0_addr1 = p0.a1; req0_addr2 = p0.a2; req0_wdata = p0.wd;
    req1_valid = p1.v; req1_write = p1.w; req1_addr1 = p1.a1; req1_addr2 = p1.a2; req1_wdata = p1.wd;
    e.cyc = cyc; e.rdy0 = 1'b0; e.rdy1 = 1'b0; e.done = 1'b0; e.rw = 1'b1;
    e.ra1 = '0; e.ra2 = '0; e.wa = '0; e.wd = '0;
    g = 2'b00;
    if (r) begin
      m_run = 1'b0; m_init_idx = 0; m_ptr = 1'b0;
      // a read whose data would land in this cycle is lost
      while (q_rsp0.size() != 0 && q_rsp0[$].cyc == cyc) void'(q_rsp0.pop_back());
      while (q_rsp1.size() != 0 && q_rsp1[$].cyc == cyc) void'(q_rsp1.pop_back());
    end else if (!m_run) begin
      e.rw = 1'b0; e.wa = 5'(m_init_idx); e.wd = INIT;
      m_mem[m_init_idx] = INIT;
      m_init_idx++;
      if (m_init_idx == NR) m_run = 1'b1;
    end else begin
      e.done = 1'b1;
      if (p0.v && p1.v) begin
        g[m_ptr] = 1'b1;
        m_ptr = !m_ptr;
      end else begin
        g = {p1.v, p0.v};
      end
      e.rdy0 = g[0]; e.rdy1 = g[1];
      if (g != 2'b00) begin
        p = g[1] ? p1 : p0;
        if (p.w) begin
          if (p.a1 != 5'd0) begin
            e.rw = 1'b0; e.wa = p.a1; e.wd = p.wd;
            m_mem[p.a1] = p.wd;
          end
        end else begin
          e.ra1 = p.a1; e.ra2 = p.a2;
          rs.cyc = cyc + 1; rs.d1 = m_mem[p.a1]; rs.d2 = m_mem[p.a2];
          if (g[1]) q_rsp1.push_back(rs);
          else q_rsp0.push_back(rs);
        end
      end
    end
    q_op.push_back(e);
    acc = g;
  endtask

  // Hold requests until the model accepts them.
  task automatic xfer(input req_t p0, input req_t p1);
    logic [1:0] acc;
    req_t a;
    req_t b;
    a = p0; b = p1;
    for (int i = 0; i < 4 && (a.v || b.v); i++) begin
      step(1'b0, a, b, acc);
      if (acc[0]) a.v = 1'b0;
      if (acc[1]) b.v = 1'b0;
    end
  endtask

  task automatic idles(input int n, input logic r);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) step(r, idle(), idle(), acc);
  endtask

  // Free-running stream: a port gets a fresh request once its current one is taken.
  task automatic stream(input int n, input bit only_reads);
    logic [1:0] acc;
    req_t a;
    req_t b;
    a = only_reads ? rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))) : rnd_req();
    b = only_reads ? rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))) : rnd_req();
    for (int i = 0; i < n; i++) begin
      step(1'b0, a, b, acc);
      if (!a.v || acc[0]) a = only_reads ? rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))) : rnd_req();
      if (!b.v || acc[1]) b = only_reads ? rd(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31))) : rnd_req();
    end
  endtask

  // Monitor: compare each cycle's command and any response against the queues.
  initial begin
    op_exp_t  e;
    rsp_exp_t r;
    bit       has;
    forever begin
      @(negedge clk);
      if (q_op.size() != 0 && q_op[0].cyc == cyc) begin
        e = q_op.pop_front();
        chk("req0_ready", 32'(req0_ready), 32'(e.rdy0));
        chk("req1_ready", 32'(req1_ready), 32'(e.rdy1));
        chk("init_done", 32'(init_done), 32'(e.done));
        chk("rf_rw_en", 32'(rf_rw_en), 32'(e.rw));
        if (e.rw) begin
          chk("rf_raddr1", 32'(rf_raddr1), 32'(e.ra1));
          chk("rf_raddr2", 32'(rf_raddr2), 32'(e.ra2));
        end else begin
          chk("rf_waddr", 32'(rf_waddr), 32'(e.wa));
          chk("rf_wdata", rf_wdata, e.wd);
        end
      end
      has = (q_rsp0.size() != 0) && (q_rsp0[0].cyc == cyc);
      chk("rsp0_valid", 32'(rsp0_valid), 32'(has));
      if (has) begin
        r = q_rsp0.pop_front();
        if (rsp0_valid) begin
          chk("rsp0_data1", rsp0_data1, r.d1);
          chk("rsp0_data2", rsp0_data2, r.d2);
          $display("rsp0 cyc=%0d d1=%h d2=%h", cyc, rsp0_data1, rsp0_data2);
        end
      end
      has = (q_rsp1.size() != 0) && (q_rsp1[0].cyc == cyc);
      chk("rsp1_valid", 32'(rsp1_valid), 32'(has));
      if (has) begin
        r = q_rsp1.pop_front();
        if (rsp1_valid) begin
          chk("rsp1_data1", rsp1_data1, r.d1);
          chk("rsp1_data2", rsp1_data2, r.d2);
          $display("rsp1 cyc=%0d d1=%h d2=%h", cyc, rsp1_data1, rsp1_data2);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_write = 1'b0; req0_addr1 = '0; req0_addr2 = '0; req0_wdata = '0;
    req1_valid = 1'b0; req1_write = 1'b0; req1_addr1 = '0; req1_addr2 = '0; req1_wdata = '0;

    // reset, full init sweep, then quiet idle
    idles(2, 1'b1);
    idles(NR, 1'b0);
    idles(3, 1'b0);

    // two writes from different ports, then a dual read of both
    xfer(wr(5'd5, 32'h12345678), idle());
    xfer(idle(), wr(5'd15, 32'habcdabcd));
    xfer(rd(5'd5, 5'd15), idle());
    idles(1, 1'b0);

    // both ports reading every cycle: alternating grants
    stream(6, 1'b1);
    idles(1, 1'b0);

    // protected r0
    xfer(idle(), wr(5'd0, 32'hffffffff));
    xfer(idle(), rd(5'd0, 5'd0));
    idles(1, 1'b0);

    // read immediately after write to the same register
    xfer(wr(5'd7, 32'h55), idle());
    xfer(rd(5'd7, 5'd7), idle());
    idles(1, 1'b0);

    // reset in the middle of the sweep, at address 10
    idles(2, 1'b1);
    idles(10, 1'b0);
    idles(1, 1'b1);
    idles(NR + 2, 1'b0);

    // reset with a read in flight
    xfer(rd(5'd3, 5'd4), idle());
    idles(2, 1'b1);
    idles(NR + 2, 1'b0);

    // randomized mixed traffic
    stream(400, 1'b0);
    idles(3, 1'b0);

    @(negedge clk); #1;
    chk("rsp0_pending", 32'(q_rsp0.size()), 32'd0);
    chk("rsp1_pending", 32'(q_rsp1.size()), 32'd0);
    chk("op_pending", 32'(q_op.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
